// File: rtl/regfile_pkg.sv
// Shared widths, clear-sequencer state encoding and packed-port slicing helper for regfile_mp.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } clr_state_t;

  // Low bit of port `port` inside a packed bus whose fields are `width` bits wide.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer for regfile_mp: walks ptr over every entry once per clr_req and
// gates the write port while it runs.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_req,
  output logic [ADDR_W-1:0] ptr,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_ready
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  clr_state_t        state;
  clr_state_t        state_nxt;
  logic [ADDR_W-1:0] ptr_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Outputs depend only on registered state/ptr, so clr_req never reaches them combinationally.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    clr_busy  = 1'b0;
    clr_done  = 1'b0;
    wr_ready  = 1'b1;
    case (state)
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt = ST_CLEAR;
          ptr_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        clr_busy = 1'b1;
        wr_ready = 1'b0;
        ptr_nxt  = ptr + ADDR_W'(1);
        if (ptr == LAST) begin
          clr_done  = 1'b1;
          state_nxt = ST_IDLE;
          ptr_nxt   = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with zero register, pending scoreboard and clear sequencer.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [ADDR_W-1:0] clr_ptr;
  logic              wr_acc;
  logic              sb_acc;

  regfile_clr_seq #(
    .ADDR_W(ADDR_W)
  ) u_clr_seq (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_req (clr_req),
    .ptr     (clr_ptr),
    .clr_busy(clr_busy),
    .clr_done(clr_done),
    .wr_ready(wr_ready)
  );

  assign wr_acc = wr_en && wr_ready && !(ZERO_REG != 0 && wr_addr == '0);
  assign sb_acc = sb_set && !clr_busy && !(ZERO_REG != 0 && sb_addr == '0);

  // Scoreboard set is applied after the write so a newer producer keeps the entry pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
      pending <= '0;
    end else if (clr_busy) begin
      mem[clr_ptr]     <= '0;
      pending[clr_ptr] <= 1'b0;
    end else begin
      if (wr_acc) begin
        mem[wr_addr]     <= wr_data;
        pending[wr_addr] <= 1'b0;
      end
      if (sb_acc) begin
        pending[sb_addr] <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    localparam int ALO = slice_lo(i, ADDR_W);
    localparam int DLO = slice_lo(i, DATA_W);

    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] data;
    logic              pend;

    assign ra = rd_addr[ALO +: ADDR_W];

    always_comb begin
      data = mem[ra];
      pend = pending[ra];
`ifdef REGFILE_BYPASS_EN
      if (wr_acc && wr_addr == ra) begin
        data = wr_data;
        pend = sb_acc && sb_addr == ra;
      end
`endif
      if (ZERO_REG != 0 && ra == '0) begin
        data = '0;
        pend = 1'b0;
      end
    end

    assign rd_data[DLO +: DATA_W] = data;
    assign rd_pending[i]          = pend;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (2 read ports, 32 x 32-bit); expectations follow
// REGFILE_BYPASS_EN when the bench is compiled with it.
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 32;

  logic                     clk     = 1'b0;
  logic                     reset_n = 1'b1;
  logic                     wr_en   = 1'b0;
  logic [ADDR_W-1:0]        wr_addr = '0;
  logic [DATA_W-1:0]        wr_data = '0;
  logic                     wr_ready;
  logic [NUM_RD*ADDR_W-1:0] rd_addr = '0;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pending;
  logic                     sb_set  = 1'b0;
  logic [ADDR_W-1:0]        sb_addr = '0;
  logic                     clr_req = 1'b0;
  logic                     clr_busy;
  logic                     clr_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_pending(rd_pending),
    .sb_set    (sb_set),
    .sb_addr   (sb_addr),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done)
  );

  // Leaves the bench 1 time unit after a rising edge, where inputs may change safely.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en   = 1'b0;
    sb_set  = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic test_reset();
    rd_addr = {5'd0, 5'd5};
    #2 reset_n = 1'b0;
    #1;
    total++; if (clr_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", clr_busy); end
    total++; if (clr_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", clr_done); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_wr_ready got=%b want=1", wr_ready); end
    total++; if (rd_data !== 64'h0) begin bad++; $display("[TB] FAIL reset_rd_data got=%h want=0", rd_data); end
    total++; if (rd_pending !== 2'b00) begin bad++; $display("[TB] FAIL reset_pending got=%b want=00", rd_pending); end
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_write();
    logic [31:0] exp_same;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'hDEADBEEF;
`else
    exp_same = 32'h0;
`endif
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr = {5'd0, 5'd5};
    #1;
    total++; if (rd_data[31:0] !== exp_same) begin bad++; $display("[TB] FAIL write_same_cycle got=%h want=%h", rd_data[31:0], exp_same); end
    tick();
    wr_en = 1'b0;
    #1;
    total++; if (rd_data[31:0] !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL write_next_cycle got=%h want=deadbeef", rd_data[31:0]); end
    total++; if (rd_data[63:32] !== 32'h0) begin bad++; $display("[TB] FAIL write_port1_x0 got=%h want=0", rd_data[63:32]); end
  endtask

  task automatic test_zero();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
    sb_set = 1'b1; sb_addr = 5'd0;
    tick();
    idle_inputs();
    rd_addr = {5'd0, 5'd0};
    #1;
    total++; if (rd_data !== 64'h0) begin bad++; $display("[TB] FAIL zero_data got=%h want=0", rd_data); end
    total++; if (rd_pending !== 2'b00) begin bad++; $display("[TB] FAIL zero_pending got=%b want=00", rd_pending); end
  endtask

  task automatic test_scoreboard();
    sb_set = 1'b1; sb_addr = 5'd7; rd_addr = {5'd7, 5'd5};
    tick();
    sb_set = 1'b0;
    #1;
    total++; if (rd_pending !== 2'b10) begin bad++; $display("[TB] FAIL sb_set got=%b want=10", rd_pending); end
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77777777;
    sb_set = 1'b1; sb_addr = 5'd7;
    tick();
    idle_inputs();
    #1;
    total++; if (rd_pending !== 2'b10) begin bad++; $display("[TB] FAIL sb_set_wins got=%b want=10", rd_pending); end
    total++; if (rd_data[63:32] !== 32'h77777777) begin bad++; $display("[TB] FAIL sb_write_data got=%h want=77777777", rd_data[63:32]); end
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h00000707;
    tick();
    wr_en = 1'b0;
    #1;
    total++; if (rd_pending !== 2'b00) begin bad++; $display("[TB] FAIL sb_write_clears got=%b want=00", rd_pending); end
    total++; if (rd_data[63:32] !== 32'h00000707) begin bad++; $display("[TB] FAIL sb_write2_data got=%h want=00000707", rd_data[63:32]); end
  endtask

  task automatic test_clear();
    for (int i = 1; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_addr = i[4:0]; wr_data = 32'(32'h1000 + i);
      tick();
    end
    wr_en = 1'b0;
    sb_set = 1'b1; sb_addr = 5'd12;
    tick();
    sb_set = 1'b0;
    rd_addr = {5'd31, 5'd12};
    #1;
    total++; if (rd_data !== {32'h0000101F, 32'h0000100C}) begin bad++; $display("[TB] FAIL fill_data got=%h want=0000101f0000100c", rd_data); end
    total++; if (rd_pending !== 2'b01) begin bad++; $display("[TB] FAIL fill_pending got=%b want=01", rd_pending); end

    clr_req = 1'b1;
    #1;
    total++; if (clr_busy !== 1'b0) begin bad++; $display("[TB] FAIL clr_req_cycle_busy got=%b want=0", clr_busy); end
    tick();
    clr_req = 1'b0;
    // Mid-clear: dropped write to x3 at cycle 5, ignored sb_set at 20, ignored clr_req at 8.
    for (int c = 1; c <= DEPTH; c++) begin
      wr_en = (c == 5); wr_addr = 5'd3; wr_data = 32'h00000BAD;
      sb_set = (c == 20); sb_addr = 5'd2;
      clr_req = (c == 8);
      rd_addr = {5'd20, 5'd3};
      #1;
      total++; if (clr_busy !== 1'b1) begin bad++; $display("[TB] FAIL clr_busy_c%0d got=%b want=1", c, clr_busy); end
      total++; if (clr_done !== (c == DEPTH)) begin bad++; $display("[TB] FAIL clr_done_c%0d got=%b want=%b", c, clr_done, (c == DEPTH)); end
      total++; if (wr_ready !== 1'b0) begin bad++; $display("[TB] FAIL clr_wr_ready_c%0d got=%b want=0", c, wr_ready); end
      if (c == 10) begin
        total++; if (rd_data !== {32'h00001014, 32'h0}) begin bad++; $display("[TB] FAIL clr_partial got=%h want=0000101400000000", rd_data); end
      end
      tick();
    end
    idle_inputs();
    #1;
    total++; if (clr_busy !== 1'b0) begin bad++; $display("[TB] FAIL clr_end_busy got=%b want=0", clr_busy); end
    total++; if (clr_done !== 1'b0) begin bad++; $display("[TB] FAIL clr_end_done got=%b want=0", clr_done); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("[TB] FAIL clr_end_wr_ready got=%b want=1", wr_ready); end
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = {a[4:0], a[4:0]};
      #1;
      total++; if (rd_data !== 64'h0 || rd_pending !== 2'b00) begin bad++; $display("[TB] FAIL clr_entry_x%0d got=%h/%b want=0/00", a, rd_data, rd_pending); end
    end
  endtask

  task automatic test_reset_mid_clear();
    tick();
    wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'h00002020;
    tick();
    wr_addr = 5'd31; wr_data = 32'h00003131;
    tick();
    wr_en = 1'b0;
    sb_set = 1'b1; sb_addr = 5'd25;
    tick();
    sb_set = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    rd_addr = {5'd31, 5'd20};
    #1;
    total++; if (clr_busy !== 1'b1) begin bad++; $display("[TB] FAIL midclr_busy_before got=%b want=1", clr_busy); end
    #1 reset_n = 1'b0;
    #1;
    total++; if (clr_busy !== 1'b0) begin bad++; $display("[TB] FAIL midclr_reset_busy got=%b want=0", clr_busy); end
    total++; if (clr_done !== 1'b0) begin bad++; $display("[TB] FAIL midclr_reset_done got=%b want=0", clr_done); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("[TB] FAIL midclr_reset_wr_ready got=%b want=1", wr_ready); end
    total++; if (rd_data !== 64'h0) begin bad++; $display("[TB] FAIL midclr_reset_data got=%h want=0", rd_data); end
    rd_addr = {5'd25, 5'd25};
    #1;
    total++; if (rd_pending !== 2'b00) begin bad++; $display("[TB] FAIL midclr_reset_pending got=%b want=00", rd_pending); end
    tick();
    reset_n = 1'b1;
    tick();
    total++; if (clr_busy !== 1'b0) begin bad++; $display("[TB] FAIL midclr_no_restart got=%b want=0", clr_busy); end
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = {a[4:0], a[4:0]};
      #1;
      total++; if (rd_data !== 64'h0) begin bad++; $display("[TB] FAIL midclr_entry_x%0d got=%h want=0", a, rd_data); end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_d1;
    logic [1:0]  exp_p;
    tick();
    sb_set = 1'b1; sb_addr = 5'd9;
    tick();
    sb_set = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5; rd_addr = {5'd9, 5'd0};
`ifdef REGFILE_BYPASS_EN
    exp_d1 = 32'hA5A5A5A5; exp_p = 2'b00;
`else
    exp_d1 = 32'h0; exp_p = 2'b10;
`endif
    #1;
    total++; if (rd_data[63:32] !== exp_d1) begin bad++; $display("[TB] FAIL byp_same_data got=%h want=%h", rd_data[63:32], exp_d1); end
    total++; if (rd_pending !== exp_p) begin bad++; $display("[TB] FAIL byp_same_pending got=%b want=%b", rd_pending, exp_p); end
    tick();
    wr_en = 1'b0;
    #1;
    total++; if (rd_data[63:32] !== 32'hA5A5A5A5) begin bad++; $display("[TB] FAIL byp_next_data got=%h want=a5a5a5a5", rd_data[63:32]); end
    total++; if (rd_pending !== 2'b00) begin bad++; $display("[TB] FAIL byp_next_pending got=%b want=00", rd_pending); end

    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h5A5A5A5A;
    sb_set = 1'b1; sb_addr = 5'd9;
`ifdef REGFILE_BYPASS_EN
    exp_d1 = 32'h5A5A5A5A; exp_p = 2'b10;
`else
    exp_d1 = 32'hA5A5A5A5; exp_p = 2'b00;
`endif
    #1;
    total++; if (rd_data[63:32] !== exp_d1) begin bad++; $display("[TB] FAIL byp_sb_data got=%h want=%h", rd_data[63:32], exp_d1); end
    total++; if (rd_pending !== exp_p) begin bad++; $display("[TB] FAIL byp_sb_pending got=%b want=%b", rd_pending, exp_p); end
    tick();
    idle_inputs();
    #1;
    total++; if (rd_data[63:32] !== 32'h5A5A5A5A || rd_pending !== 2'b10) begin bad++; $display("[TB] FAIL byp_sb_after got=%h/%b want=5a5a5a5a/10", rd_data[63:32], rd_pending); end

    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr = {5'd0, 5'd0};
    #1;
    total++; if (rd_data !== 64'h0) begin bad++; $display("[TB] FAIL byp_zero_reg got=%h want=0", rd_data); end
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_zero();
    test_scoreboard();
    test_clear();
    test_reset_mid_clear();
    test_bypass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read-port integer register file for the RV32 core datapath. It is the successor to the 32x32 two-read/one-write file. It adds:
- a configurable number of read ports;
- a hardwired zero register;
- a per-entry pending (scoreboard) bit for hazard detection;
- a multi-cycle synchronous clear sequencer.

It sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = entry 0 reads as zero and ignores writes/sets

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
wr_en  input  1  write request
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
wr_ready  output  1  write accepted this cycle (low while clearing)
rd_addr  input  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  packed read data, combinational
rd_pending  output  NUM_RD  pending bit of addressed entry, per port
sb_set  input  1  mark sb_addr pending (instruction issued with destination)
sb_addr  input  ADDR_W  scoreboard set address
clr_req  input  1  start synchronous clear of all entries
clr_busy  output  1  clear sequence in progress
clr_done  output  1  one-cycle pulse on final clear cycle

Behaviour:
- Reset: asynchronous, active-low, one clock (clk), per the decided interface.
  - reset_n low: all entries = 0, all pending bits = 0, FSM = IDLE.
  - Outputs: clr_busy=0, clr_done=0, wr_ready=1.
  - Reset asserted mid-clear aborts the sequence immediately.
- Reads: combinational from the array, zero latency.
  - ZERO_REG=1 and address 0: rd_data=0, rd_pending=0.
  - No write-to-read bypass unless the optional feature is enabled; a same-cycle write is visible next cycle.
- Write: on posedge when wr_en && wr_ready.
  - entry[wr_addr] <= wr_data and pending[wr_addr] <= 0.
  - Ignored for address 0 when ZERO_REG=1.
- Scoreboard set: on posedge when sb_set, pending[sb_addr] <= 1.
  - sb_set and an accepted write to the same address in the same cycle: set wins, pending stays 1 (newer producer).
- Clear FSM: IDLE -> CLEAR -> IDLE.
  - IDLE: clr_req=1 -> CLEAR, ptr=0, clr_busy=1 from the next cycle.
  - CLEAR: each cycle entry[ptr] <= 0 and pending[ptr] <= 0, then ptr++.
  - ptr == DEPTH-1: clr_done=1 for that cycle, next state IDLE. The sequence takes exactly DEPTH cycles.
  - clr_req while busy is ignored; no restart.
- During CLEAR:
  - wr_ready=0 and writes are dropped; the writer must hold the request.
  - sb_set is ignored.
  - Reads return the current, partially cleared contents.
- ptr is ADDR_W bits wide; DEPTH-1 is its last value, with no wrap beyond.
- The FSM drives clr_busy and clr_done directly from state/ptr registers.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: a read port whose address equals wr_addr while a write is accepted returns wr_data combinationally, and rd_pending for that port = 0 unless sb_set targets the same address. The zero register is never bypassed.
- Undefined: no forwarding; reads return array contents only.

Decomposition:
- Shared package regfile_pkg:
  - default widths (DATA_W, ADDR_W);
  - clear FSM state enum (ST_IDLE, ST_CLEAR);
  - function to unpack port i address/data slices.
- One sub-module: regfile_clr_seq, holding the FSM, ptr, clr_busy, clr_done and wr_ready.
- The array, scoreboard and read muxes stay in the top.

Test Plan:
1. Reset then write 0xDEADBEEF to x5 and read x5 on port 0 next cycle -> rd_data[31:0]=0xDEADBEEF; same-cycle read returns 0 (bypass off).
2. Write 0x12345678 to x0, read x0 on all ports -> 0x00000000, rd_pending=0.
3. sb_set x7 -> rd_pending for x7 = 1. Then write x7 with concurrent sb_set x7 -> pending stays 1. Then write x7 alone -> pending 0.
4. Fill all 32 entries, pulse clr_req:
   - clr_busy high for 32 cycles, clr_done on the 32nd;
   - a write to x3 mid-clear sees wr_ready=0 and is dropped;
   - all entries = 0 afterwards.
5. Deassert reset_n asynchronously at clear cycle 10 -> all outputs at reset values without a clock edge; array all zero.
6. With REGFILE_BYPASS_EN: write 0xA5A5A5A5 to x9 while port 1 reads x9 -> same-cycle rd_data port 1 = 0xA5A5A5A5.
